// File: rtl/dpc_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// dpc_cfg_ctrl
//
// Configuration controller for the myfilter FIR datapath. A host writes
// NTAPS shadow coefficients over a req/ack register bus. A "start" command
// parks the datapath controller in PROGRAM by raising ul_out, streams the
// shadow coefficients into the datapath coefficient store, then drops ul_out.
// A "stop" command pulses dl_out for one cycle.
//
// Register map:
//   0 .. NTAPS-1 : coefficient shadow registers (write; read only with readback)
//   NTAPS .. 6   : unused, writes acked and ignored, reads return 0
//   7            : write CTRL  (bit1 = stop, wins over bit0 = start)
//                  read STATUS ({busy, dirty, running} in bits [2:0])
//
// Build option:
//   CFG_READBACK_EN  when defined, coefficient reads return shadow[addr];
//                    when undefined they return 0 and no shadow read mux exists.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req_in        in   host request, held until ack_out is seen
//   we_in         in   1 = write, 0 = read
//   addr_in       in   register address
//   wdata_in      in   write data
//   ack_out       out  one-cycle acknowledge
//   rdata_out     out  read data, valid with ack_out, otherwise 0
//   ul_out        out  upload request to the datapath controller
//   dl_out        out  stop request to the datapath controller
//   coef_we_out   out  coefficient store write strobe
//   coef_addr_out out  coefficient index being written
//   coef_out      out  coefficient value being written
// -----------------------------------------------------------------------------
module dpc_cfg_ctrl #(
  parameter int NTAPS  = 5,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              ul_out,
  output logic              dl_out,
  output logic              coef_we_out,
  output logic [ADDR_W-1:0] coef_addr_out,
  output logic [DATA_W-1:0] coef_out
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   NTAPS_L   = NTAPS[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACK    = 3'd1,
    S_REL    = 3'd2,
    S_UPLOAD = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [DATA_W-1:0]   shadow_q [NTAPS];
  logic [DATA_W-1:0]   shadow_d [NTAPS];
  logic                running_q,   running_d;
  logic                dirty_q,     dirty_d;
  logic                start_q,     start_d;
  logic                stop_q,      stop_d;
  logic                rel_ok_q,    rel_ok_d;
  logic [ADDR_W:0]     cnt_q,       cnt_d;
  logic                ack_q,       ack_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;
  logic                ul_q,        ul_d;
  logic                dl_q,        dl_d;
  logic                coef_we_q,   coef_we_d;
  logic [ADDR_W-1:0]   coef_addr_q, coef_addr_d;
  logic [DATA_W-1:0]   coef_q,      coef_d;

  logic                is_coef;
  logic                is_ctrl;
  logic                busy;
  logic [DATA_W-1:0]   rd_word;

  assign is_coef = ({1'b0, addr_in} < NTAPS_L);
  assign is_ctrl = (addr_in == CTRL_ADDR);
  assign busy    = (state_q != S_IDLE) && (state_q != S_REL);

  // Read data selection for the addressed register.
  always_comb begin
    rd_word = '0;
    if (is_ctrl) begin
      rd_word[2:0] = {busy, dirty_q, running_q};
    end
`ifdef CFG_READBACK_EN
    else if (is_coef) begin
      rd_word = shadow_q[addr_in];
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    running_d   = running_q;
    dirty_d     = dirty_q;
    start_d     = start_q;
    stop_d      = stop_q;
    cnt_d       = cnt_q;
    ul_d        = ul_q;
    ack_d       = 1'b0;
    rdata_d     = '0;
    dl_d        = 1'b0;
    coef_we_d   = 1'b0;
    coef_addr_d = '0;
    coef_d      = '0;
    // Remembers that the host has dropped req_in since the last ack, so a
    // new request raised during a long upload does not stall REL.
    rel_ok_d    = rel_ok_q | ~req_in;

    case (state_q)
      S_IDLE: begin
        if (req_in) begin
          state_d  = S_ACK;
          ack_d    = 1'b1;
          rel_ok_d = 1'b0;
          start_d  = 1'b0;
          stop_d   = 1'b0;
          if (we_in) begin
            if (is_coef) begin
              shadow_d[addr_in] = wdata_in;
              dirty_d           = 1'b1;
            end else if (is_ctrl) begin
              if (wdata_in[1]) begin
                stop_d    = 1'b1;
                dl_d      = 1'b1;
                running_d = 1'b0;
              end else if (wdata_in[0]) begin
                start_d = 1'b1;
                ul_d    = 1'b1;
              end
            end
          end else begin
            rdata_d = rd_word;
          end
        end
      end

      S_ACK: begin
        if (start_q) begin
          state_d     = S_UPLOAD;
          coef_we_d   = 1'b1;
          coef_addr_d = '0;
          coef_d      = shadow_q[0];
          cnt_d       = {{ADDR_W{1'b0}}, 1'b1};
        end else if (stop_q) begin
          state_d = S_STOP;
        end else begin
          state_d = S_REL;
        end
      end

      S_UPLOAD: begin
        if (cnt_q < NTAPS_L) begin
          coef_we_d   = 1'b1;
          coef_addr_d = cnt_q[ADDR_W-1:0];
          coef_d      = shadow_q[cnt_q[ADDR_W-1:0]];
          cnt_d       = cnt_q + 1'b1;
        end else begin
          // Last write was the previous cycle: release the datapath.
          ul_d      = 1'b0;
          dirty_d   = 1'b0;
          running_d = 1'b1;
          start_d   = 1'b0;
          cnt_d     = '0;
          state_d   = S_REL;
        end
      end

      S_STOP: begin
        stop_d  = 1'b0;
        state_d = S_REL;
      end

      S_REL: begin
        if (!req_in || rel_ok_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= '0;
      end
      running_q   <= 1'b0;
      dirty_q     <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      rel_ok_q    <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      ul_q        <= 1'b0;
      dl_q        <= 1'b0;
      coef_we_q   <= 1'b0;
      coef_addr_q <= '0;
      coef_q      <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      running_q   <= running_d;
      dirty_q     <= dirty_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      rel_ok_q    <= rel_ok_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      ul_q        <= ul_d;
      dl_q        <= dl_d;
      coef_we_q   <= coef_we_d;
      coef_addr_q <= coef_addr_d;
      coef_q      <= coef_d;
    end
  end

  assign ack_out       = ack_q;
  assign rdata_out     = rdata_q;
  assign ul_out        = ul_q;
  assign dl_out        = dl_q;
  assign coef_we_out   = coef_we_q;
  assign coef_addr_out = coef_addr_q;
  assign coef_out      = coef_q;

endmodule

// File: tb/tb_dpc_cfg_ctrl.sv
// Directed bench for dpc_cfg_ctrl: register access, upload, stop, request
// hold-off during upload and reset in the middle of an upload.
module tb_dpc_cfg_ctrl;
  localparam int NTAPS  = 5;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_in = 1'b0;
  logic              we_in = 1'b0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [DATA_W-1:0] wdata_in = '0;
  logic              ack_out;
  logic [DATA_W-1:0] rdata_out;
  logic              ul_out;
  logic              dl_out;
  logic              coef_we_out;
  logic [ADDR_W-1:0] coef_addr_out;
  logic [DATA_W-1:0] coef_out;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] cv [NTAPS] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
  logic [DATA_W-1:0] rd;
  int                lat;
  int                seen;

  dpc_cfg_ctrl #(.NTAPS(NTAPS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .we_in(we_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .ack_out(ack_out),
    .rdata_out(rdata_out), .ul_out(ul_out), .dl_out(dl_out),
    .coef_we_out(coef_we_out), .coef_addr_out(coef_addr_out),
    .coef_out(coef_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issues one access and returns in the ack cycle (1 ns after its edge)
  // with req_in already dropped.
  task automatic access(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d,
                        output logic [DATA_W-1:0] r, output int l);
    req_in = 1'b1; we_in = w; addr_in = a; wdata_in = d;
    l = 0;
    do begin @(posedge clk); #1; l++; end while (ack_out !== 1'b1 && l < 40);
    r = rdata_out;
    chk("ack_seen", {31'd0, ack_out}, 32'd1);
    req_in = 1'b0; we_in = 1'b0; addr_in = '0; wdata_in = '0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    access(1'b1, a, d, rd, lat);
    idle(2);
  endtask

  task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] exp);
    access(1'b0, a, '0, rd, lat);
    chk(tag, {16'd0, rd}, {16'd0, exp});
    idle(2);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ul", {31'd0, ul_out}, 32'd0);
    chk("rst_dl", {31'd0, dl_out}, 32'd0);
    chk("rst_we", {31'd0, coef_we_out}, 32'd0);
    chk("rst_ack", {31'd0, ack_out}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_out}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: status read after reset, ack one cycle after request
    access(1'b0, 3'd7, '0, rd, lat);
    chk("s1_latency", lat, 32'd1);
    chk("s1_status", {16'd0, rd}, 32'd0);
    chk("s1_ul", {31'd0, ul_out}, 32'd0);
    chk("s1_dl", {31'd0, dl_out}, 32'd0);
    chk("s1_we", {31'd0, coef_we_out}, 32'd0);
    idle(1);
    chk("s1_ack_one_cycle", {31'd0, ack_out}, 32'd0);
    chk("s1_rdata_idle", {16'd0, rdata_out}, 32'd0);
    idle(1);

    // 2: load coefficients and upload
    for (int i = 0; i < NTAPS; i++) wr(i[ADDR_W-1:0], cv[i]);
    rd_chk("s2_status_dirty", 3'd7, 16'h0002);
    access(1'b1, 3'd7, 16'h0001, rd, lat);
    chk("s2_ul_ack", {31'd0, ul_out}, 32'd1);
    chk("s2_we_ack", {31'd0, coef_we_out}, 32'd0);
    chk("s2_dl_ack", {31'd0, dl_out}, 32'd0);
    for (int i = 0; i < NTAPS; i++) begin
      idle(1);
      chk("s2_we", {31'd0, coef_we_out}, 32'd1);
      chk("s2_addr", {29'd0, coef_addr_out}, i);
      chk("s2_coef", {16'd0, coef_out}, {16'd0, cv[i]});
      chk("s2_ul", {31'd0, ul_out}, 32'd1);
    end
    idle(1);
    chk("s2_ul_fall", {31'd0, ul_out}, 32'd0);
    chk("s2_we_fall", {31'd0, coef_we_out}, 32'd0);
    idle(2);
    rd_chk("s2_status", 3'd7, 16'h0001);
`ifdef CFG_READBACK_EN
    rd_chk("s2_readback", 3'd2, 16'h0033);
`else
    rd_chk("s2_readback", 3'd2, 16'h0000);
`endif
    rd_chk("s2_unused_read", 3'd6, 16'h0000);
    wr(3'd5, 16'hFFFF);
    rd_chk("s2_unused_write", 3'd7, 16'h0001);

    // 3: stop
    access(1'b1, 3'd7, 16'h0002, rd, lat);
    chk("s3_dl", {31'd0, dl_out}, 32'd1);
    chk("s3_ul", {31'd0, ul_out}, 32'd0);
    idle(1);
    chk("s3_dl_one_cycle", {31'd0, dl_out}, 32'd0);
    chk("s3_ul_after", {31'd0, ul_out}, 32'd0);
    idle(2);
    rd_chk("s3_status", 3'd7, 16'h0000);

    // 4: stop and start together, stop wins
    access(1'b1, 3'd7, 16'h0003, rd, lat);
    chk("s4_dl", {31'd0, dl_out}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen += int'(ul_out) + int'(coef_we_out);
      idle(1);
      seen += int'(dl_out) + int'(ul_out) + int'(coef_we_out);
    end
    chk("s4_no_upload_one_dl", seen, 32'd0);
    rd_chk("s4_status", 3'd7, 16'h0000);

    // 5: request held during upload is deferred until the upload ends
    access(1'b1, 3'd7, 16'h0001, rd, lat);
    idle(1);
    chk("s5_we0", {31'd0, coef_we_out}, 32'd1);
    chk("s5_coef0", {16'd0, coef_out}, 32'h0011);
    req_in = 1'b1; we_in = 1'b1; addr_in = 3'd0; wdata_in = 16'h0BBB;
    seen = 0;
    for (int i = 1; i < NTAPS; i++) begin
      idle(1);
      seen += int'(ack_out);
      chk("s5_coef", {16'd0, coef_out}, {16'd0, cv[i]});
    end
    idle(1);
    seen += int'(ack_out);
    chk("s5_ul_fall", {31'd0, ul_out}, 32'd0);
    chk("s5_no_ack_during_upload", seen, 32'd0);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ack_out !== 1'b1 && lat < 20);
    chk("s5_deferred_ack", {31'd0, ack_out}, 32'd1);
    chk("s5_deferred_latency", lat, 32'd2);
    req_in = 1'b0; we_in = 1'b0; wdata_in = '0;
    idle(2);
    rd_chk("s5_status", 3'd7, 16'h0003);
`ifdef CFG_READBACK_EN
    rd_chk("s5_readback", 3'd0, 16'h0BBB);
`else
    rd_chk("s5_readback", 3'd0, 16'h0000);
`endif

    // 6: reset in the middle of an upload
    access(1'b1, 3'd7, 16'h0001, rd, lat);
    idle(3);
    chk("s6_we2", {31'd0, coef_we_out}, 32'd1);
    chk("s6_addr2", {29'd0, coef_addr_out}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_ul_async", {31'd0, ul_out}, 32'd0);
    chk("s6_we_async", {31'd0, coef_we_out}, 32'd0);
    chk("s6_coef_async", {16'd0, coef_out}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      seen += int'(ul_out) + int'(coef_we_out) + int'(dl_out);
    end
    chk("s6_no_resume", seen, 32'd0);
    rd_chk("s6_status", 3'd7, 16'h0000);
    rd_chk("s6_readback", 3'd0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
